cu_decode_stage: RTL

//  Registered, parametrised decode stage for the 5-stage OTTER: decodes the IF/ID instruction

---
 rtl/cu_decode_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cu_decode_stage.sv
// cu_decode_stage: registered OTTER decode stage. Decodes the IF/ID instruction
// into ALU/regfile/memory/CSR controls and holds them in the ID/EX register,
// with valid/ready flow control, flush, load-use bubbles and a post-CSR drain.
module cu_decode_stage #(
    parameter logic        SUPPORT_CSR    = 1'b1,
    parameter logic        SUPPORT_MULDIV = 1'b1,
    parameter logic        LOAD_USE_STALL = 1'b1,
    parameter int unsigned CSR_DRAIN      = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] instr,
    output logic        if_ready,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  alu_fun,
    output logic [1:0]  alu_srcA,
    output logic [2:0]  alu_srcB,
    output logic [1:0]  rf_wr_sel,
    output logic        regWrite,
    output logic        memWrite,
    output logic        memRead2,
    output logic        csr_WE,
    output logic        mret_exec,
    output logic        branch,
    output logic        muldiv,
    output logic        illegal,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [3:0] DRAIN_INIT = 4'(CSR_DRAIN);

    typedef struct packed {
        logic [3:0] alu_fun;
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic [1:0] wr_sel;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       csr_we;
        logic       mret;
        logic       branch;
        logic       muldiv;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic       dec_serial;
    logic       bad;
    logic       valid_q;
    logic [0:0] state;
    logic [3:0] count;
    logic       advance;
    logic       accept;
    logic       hazard;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Combinational decode of the incoming instruction; unused register fields stay 0
    always_comb begin
        dec        = '0;
        dec_serial = 1'b0;
        bad        = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.wr_sel    = 2'd3;
                dec.rd        = instr[11:7];
                dec.rs1       = instr[19:15];
                dec.rs2       = instr[24:20];
                dec.alu_fun   = {f7[5], f3};
                if (f7 == 7'b0000001) begin
                    dec.muldiv  = 1'b1;
                    dec.alu_fun = {1'b0, f3};
                    if (!SUPPORT_MULDIV) bad = 1'b1;
                end
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.wr_sel    = 2'd3;
                dec.src_b     = 3'd1;
                dec.rd        = instr[11:7];
                dec.rs1       = instr[19:15];
                dec.alu_fun   = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
            end
            OP_LOAD: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.src_b     = 3'd1;
                dec.wr_sel    = 2'd2;
                dec.rd        = instr[11:7];
                dec.rs1       = instr[19:15];
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.src_b     = 3'd2;
                dec.rs1       = instr[19:15];
                dec.rs2       = instr[24:20];
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.src_a     = 2'd1;
                dec.alu_fun   = 4'b1001;
                dec.wr_sel    = 2'd3;
                dec.rd        = instr[11:7];
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.src_a     = 2'd1;
                dec.src_b     = 3'd3;
                dec.wr_sel    = 2'd3;
                dec.rd        = instr[11:7];
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.rd        = instr[11:7];
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.rd        = instr[11:7];
                dec.rs1       = instr[19:15];
            end
            OP_SYS: begin
                dec_serial = 1'b1;
                case (f3)
                    3'b000: dec.mret = 1'b1;
                    3'b001: dec.alu_fun = 4'b1001;
                    3'b010: begin
                        dec.src_b   = 3'd4;
                        dec.alu_fun = 4'b0110;
                    end
                    3'b011: begin
                        dec.src_a   = 2'd2;
                        dec.src_b   = 3'd4;
                        dec.alu_fun = 4'b0111;
                    end
                    default: bad = 1'b1;
                endcase
                if (f3 != 3'b000) begin
                    dec.csr_we    = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wr_sel    = 2'd1;
                    dec.rd        = instr[11:7];
                    dec.rs1       = instr[19:15];
                end
                if (!SUPPORT_CSR) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_serial  = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    assign advance  = ~valid_q | ex_ready;
    assign hazard   = LOAD_USE_STALL && valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                      if_valid && ((dec.rs1 == ctrl_q.rd) || (dec.rs2 == ctrl_q.rd));
    assign if_ready = ~RST & advance & (state == ST_RUN) & ~hazard & ~flush;
    assign accept   = if_valid & if_ready;

    // ID/EX register: cleared on reset/flush, loads decode or a bubble when execute can take it
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (advance) begin
            if (accept) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end
    end

    // Serialisation FSM: holds off fetch for DRAIN_INIT cycles after a CSR/MRET is accepted
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state <= ST_RUN;
            count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && dec_serial && (DRAIN_INIT != 4'd0)) begin
                        state <= ST_DRAIN;
                        count <= DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (count <= 4'd1) begin
                        state <= ST_RUN;
                        count <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    count <= '0;
                end
            endcase
        end
    end

    assign ex_valid  = valid_q;
    assign alu_fun   = ctrl_q.alu_fun;
    assign alu_srcA  = ctrl_q.src_a;
    assign alu_srcB  = ctrl_q.src_b;
    assign rf_wr_sel = ctrl_q.wr_sel;
    assign regWrite  = ctrl_q.reg_write;
    assign memWrite  = ctrl_q.mem_write;
    assign memRead2  = ctrl_q.mem_read;
    assign csr_WE    = ctrl_q.csr_we;
    assign mret_exec = ctrl_q.mret;
    assign branch    = ctrl_q.branch;
    assign muldiv    = ctrl_q.muldiv;
    assign illegal   = ctrl_q.illegal;
    assign rd        = ctrl_q.rd;
    assign rs1       = ctrl_q.rs1;
    assign rs2       = ctrl_q.rs2;

endmodule
